// File: rtl/and_arb_pkg.sv
// Shared types and constants for the round-robin AND-unit arbiter.
package and_arb_pkg;

    // Default operand width and default number of requesters.
    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int DEFAULT_NUM_REQ    = 4;

    // Arbiter FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Width of a requester tag. The floor of 1 keeps NUM_REQ=2 (and the
    // degenerate single-bit case) from producing a zero-width vector.
    function automatic int id_width(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/multi_bit.sv
// Shared bitwise-AND datapath unit: y = a & b, with no carry and no width growth.
module multi_bit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] y_out
);

    // Purely combinational bitwise AND.
    assign y_out = a_in & b_in;

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req_in,
    input  logic [ID_WIDTH-1:0] ptr_in,
    output logic [NUM_REQ-1:0]  grant_out,
    output logic [ID_WIDTH-1:0] idx_out,
    output logic                any_out
);

    int w_j;

    // Scan ptr, ptr+1, ... modulo NUM_REQ; the first set bit wins.
    always_comb begin
        grant_out = '0;
        idx_out   = '0;
        any_out   = 1'b0;
        w_j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = int'(ptr_in) + k;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            if (!any_out && req_in[w_j]) begin
                any_out        = 1'b1;
                grant_out[w_j] = 1'b1;
                idx_out        = ID_WIDTH'(w_j);
            end
        end
    end

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one AND unit among NUM_REQ requesters.
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high; valid/data must be held until then.
module and_unit_arbiter
    import and_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    localparam int ID_WIDTH  = id_width(NUM_REQ)
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] a_bus_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] b_bus_in,
    output logic                          res_valid_out,
    input  logic                          res_ready_in,
    output logic [DATA_WIDTH-1:0]         res_data_out,
    output logic [ID_WIDTH-1:0]           res_id_out,
    output logic [1:0]                    dbg_state_out
);

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [ID_WIDTH-1:0]   r_g;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic [ID_WIDTH-1:0]   r_res_id;
    logic                  r_res_valid;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_WIDTH-1:0]   w_idx;
    logic                  w_any;
    logic [DATA_WIDTH-1:0] w_y;

    rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .req_in    (req_valid_in),
        .ptr_in    (r_rr_ptr),
        .grant_out (w_grant),
        .idx_out   (w_idx),
        .any_out   (w_any)
    );

    // The latched operands are the only source of the shared unit's inputs.
    multi_bit #(
        .WIDTH (DATA_WIDTH)
    ) u_and (
        .a_in  (r_a),
        .b_in  (r_b),
        .y_out (w_y)
    );

    // Accept is offered only in IDLE, and never while reset is asserted.
    assign req_ready_out = (r_state == IDLE && rst_n_in) ? w_grant : '0;

    assign res_valid_out = r_res_valid;
    assign res_data_out  = r_res_data;
    assign res_id_out    = r_res_id;
    assign dbg_state_out = r_state;

    // FSM: IDLE grants and captures, EXEC registers the result, HOLD waits for drain.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_g         <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= a_bus_in[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
                        r_b     <= b_bus_in[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
                        r_g     <= w_idx;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_res_data  <= w_y;
                    r_res_id    <= r_g;
                    r_res_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready_in) begin
                        r_res_valid <= 1'b0;
                        r_rr_ptr    <= (r_g == ID_WIDTH'(NUM_REQ-1)) ? '0 : r_g + ID_WIDTH'(1);
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed, table-driven bench for the round-robin AND-unit arbiter.
module tb_and_unit_arbiter;
    import and_arb_pkg::*;

    localparam int DW = 4;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk_in;
    logic              rst_n_in;
    logic [NR-1:0]     req_valid_in;
    logic [NR-1:0]     req_ready_out;
    logic [NR*DW-1:0]  a_bus_in;
    logic [NR*DW-1:0]  b_bus_in;
    logic              res_valid_out;
    logic              res_ready_in;
    logic [DW-1:0]     res_data_out;
    logic [IW-1:0]     res_id_out;
    logic [1:0]        dbg_state_out;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [NR-1:0]    vld;
        logic [NR*DW-1:0] a;
        logic [NR*DW-1:0] b;
        int               exp_id;
        logic [DW-1:0]    exp_data;
    } vec_t;

    vec_t vecs[9];

    and_unit_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .a_bus_in      (a_bus_in),
        .b_bus_in      (b_bus_in),
        .res_valid_out (res_valid_out),
        .res_ready_in  (res_ready_in),
        .res_data_out  (res_data_out),
        .res_id_out    (res_id_out),
        .dbg_state_out (dbg_state_out)
    );

    // Clock and reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_reset();
        rst_n_in     = 1'b0;
        req_valid_in = '0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // One full transaction with res_ready_in high: grant, EXEC, result, drain.
    task automatic do_txn(input vec_t v, input string tag);
        int n;
        @(negedge clk_in);
        req_valid_in = v.vld;
        a_bus_in     = v.a;
        b_bus_in     = v.b;
        res_ready_in = 1'b1;
        #1;
        n = 0;
        while (req_ready_out == '0 && n < 20) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        chk({tag, " grant"}, 32'(req_ready_out), 32'(4'b0001 << v.exp_id));
        @(negedge clk_in);
        chk({tag, " exec_state"}, 32'(dbg_state_out), 32'(EXEC));
        chk({tag, " exec_noready"}, 32'(req_ready_out), 32'h0);
        chk({tag, " exec_novalid"}, 32'(res_valid_out), 32'h0);
        @(negedge clk_in);
        chk({tag, " res_valid"}, 32'(res_valid_out), 32'h1);
        chk({tag, " res_data"}, 32'(res_data_out), 32'(v.exp_data));
        chk({tag, " res_id"}, 32'(res_id_out), 32'(v.exp_id));
    endtask

    // Scoreboard-free directed sequences with hand-computed expectations
    initial begin
        n_cmp = 0;
        n_err = 0;
        req_valid_in = '0;
        a_bus_in     = '0;
        b_bus_in     = '0;
        res_ready_in = 1'b1;

        //              vld      a         b         id data
        vecs[0] = '{4'b0001, 16'h000C, 16'h000A, 0, 4'h8};
        vecs[1] = '{4'b1111, 16'hFFFF, 16'h8421, 0, 4'h1};
        vecs[2] = '{4'b1111, 16'hFFFF, 16'h8421, 1, 4'h2};
        vecs[3] = '{4'b1111, 16'hFFFF, 16'h8421, 2, 4'h4};
        vecs[4] = '{4'b1111, 16'hFFFF, 16'h8421, 3, 4'h8};
        vecs[5] = '{4'b1111, 16'hFFFF, 16'h8421, 0, 4'h1};
        vecs[6] = '{4'b1000, 16'hF000, 16'h3000, 3, 4'h3};
        vecs[7] = '{4'b0101, 16'h0509, 16'h0306, 0, 4'h0};
        vecs[8] = '{4'b0101, 16'h0509, 16'h0306, 2, 4'h1};

        apply_reset();
        #1;
        chk("rst res_valid", 32'(res_valid_out), 32'h0);
        chk("rst res_data", 32'(res_data_out), 32'h0);
        chk("rst res_id", 32'(res_id_out), 32'h0);
        chk("rst req_ready", 32'(req_ready_out), 32'h0);
        chk("rst state", 32'(dbg_state_out), 32'(IDLE));

        // Single request; back to IDLE afterwards.
        do_txn(vecs[0], "single");
        req_valid_in = '0;
        @(negedge clk_in);
        chk("single idle", 32'(dbg_state_out), 32'(IDLE));
        chk("single drained", 32'(res_valid_out), 32'h0);

        // All four valid from pointer 0, then wrap through req3 to req0/req2.
        apply_reset();
        for (int i = 1; i < 9; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Operand change during EXEC must not affect the result (ptr now 3).
        @(negedge clk_in);
        req_valid_in = 4'b0010;
        a_bus_in     = 16'h0060;
        b_bus_in     = 16'h0070;
        #1;
        chk("opchg grant", 32'(req_ready_out), 32'h2);
        @(posedge clk_in);
        #1;
        a_bus_in     = 16'h0000;
        b_bus_in     = 16'h0000;
        req_valid_in = '0;
        @(negedge clk_in);
        chk("opchg exec", 32'(dbg_state_out), 32'(EXEC));
        @(negedge clk_in);
        chk("opchg data", 32'(res_data_out), 32'h6);
        chk("opchg id", 32'(res_id_out), 32'h1);

        // Backpressure: result held for 5 cycles, requests get no accept.
        @(negedge clk_in);
        res_ready_in = 1'b0;
        req_valid_in = 4'b0001;
        a_bus_in     = 16'h000E;
        b_bus_in     = 16'h0007;
        #1;
        chk("bp grant", 32'(req_ready_out), 32'h1);
        @(posedge clk_in);
        #1;
        req_valid_in = 4'b0011;
        repeat (2) @(negedge clk_in);
        for (int c = 0; c < 5; c++) begin
            chk("bp state", 32'(dbg_state_out), 32'(HOLD));
            chk("bp valid", 32'(res_valid_out), 32'h1);
            chk("bp data", 32'(res_data_out), 32'h6);
            chk("bp id", 32'(res_id_out), 32'h0);
            chk("bp noready", 32'(req_ready_out), 32'h0);
            @(negedge clk_in);
        end
        res_ready_in = 1'b1;
        @(negedge clk_in);
        chk("bp release", 32'(res_valid_out), 32'h0);
        chk("bp idle", 32'(dbg_state_out), 32'(IDLE));
        chk("bp next grant", 32'(req_ready_out), 32'h2);
        req_valid_in = '0;

        // Reset while a result is held (ptr now 1, so req2 is granted).
        @(negedge clk_in);
        res_ready_in = 1'b0;
        req_valid_in = 4'b0100;
        a_bus_in     = 16'h0F00;
        b_bus_in     = 16'h0300;
        #1;
        chk("rsthold grant", 32'(req_ready_out), 32'h4);
        @(posedge clk_in);
        #1;
        req_valid_in = 4'b1010;
        repeat (2) @(negedge clk_in);
        chk("rsthold valid", 32'(res_valid_out), 32'h1);
        chk("rsthold data", 32'(res_data_out), 32'h3);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("rsthold drop valid", 32'(res_valid_out), 32'h0);
        chk("rsthold drop data", 32'(res_data_out), 32'h0);
        chk("rsthold drop id", 32'(res_id_out), 32'h0);
        chk("rsthold state", 32'(dbg_state_out), 32'(IDLE));
        chk("rsthold noready", 32'(req_ready_out), 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        chk("rsthold lowest grant", 32'(req_ready_out), 32'h2);
        req_valid_in = '0;
        do_txn('{4'b1010, 16'h00A0, 16'h00F0, 1, 4'hA}, "post_rst");
        @(negedge clk_in);
        chk("final idle", 32'(dbg_state_out), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
